// File: rtl/wave_capture_ctrl_pkg.sv
// Shared codes and defaults for the scope waveform capture controller.
package wave_capture_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_PRE = 3'd1, ST_ARMED = 3'd2, ST_POST = 3'd3, ST_DONE = 3'd4
  } cap_state_e;

  typedef enum logic [1:0] {
    MODE_AUTO = 2'd0, MODE_NORMAL = 2'd1, MODE_SINGLE = 2'd2, MODE_STOP = 2'd3
  } cap_mode_e;

  localparam int DEPTH_DEF = 200;
  localparam int AW_DEF    = 8;
  localparam int DW_DEF    = 8;
  localparam int X0_DEF    = 100;
endpackage

// File: rtl/wave_capture_ctrl_if.sv
// Sample stream in, RAM write/read port out.
interface wave_capture_ctrl_if #(parameter int AW = 8, parameter int DW = 8);
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic          ram_wren;
  logic [AW-1:0] ram_wraddr;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_rdaddr;

  modport master (input adc_data, adc_valid,
                  output ram_wren, ram_wraddr, ram_data, ram_rdaddr);
  modport slave  (output adc_data, adc_valid,
                  input ram_wren, ram_wraddr, ram_data, ram_rdaddr);
endinterface

// File: rtl/wave_capture_ctrl_trig_detect.sv
// Level/slope trigger comparator between the incoming sample and the previous one.
module trig_detect #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sample,
  input  logic          valid,
  input  logic [DW-1:0] level,
  input  logic          slope,
  input  logic          en,
  output logic          trig_hit
);
  // The incoming sample becomes s_cur on this edge; s_prev is the last one.
  logic [DW-1:0] s_prev;
  logic          rising, falling;

  always_ff @(posedge clk) begin
    if (rst)        s_prev <= '0;
    else if (valid) s_prev <= sample;
  end

  assign rising   = (s_prev < level) && (sample >= level);
  assign falling  = (s_prev > level) && (sample <= level);
  assign trig_hit = en && valid && (slope ? falling : rising);
endmodule

// File: rtl/wave_capture_ctrl.sv
// Pre/post-trigger capture sequencer and trigger-aligned read addressing.
module wave_capture_ctrl
  import wave_capture_ctrl_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int PRE_DEPTH = 50,
  parameter int X0        = X0_DEF,
  parameter int AUTO_TO   = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  wave_capture_ctrl_if.master bus,
  input  logic [DW-1:0]       trig_level,
  input  logic                trig_slope,
  input  logic [1:0]          mode,
  input  logic                arm,
  input  logic                frame_sync,
  input  logic [9:0]          value_x,
  output logic                frame_ready,
  output logic [2:0]          cap_state
);
  localparam int          TW   = $clog2(AUTO_TO + 1);
  localparam logic [AW:0] DEP  = (AW+1)'(DEPTH);
  localparam logic [9:0]  XLO  = 10'(X0);
  localparam logic [9:0]  XHI  = 10'(X0 + DEPTH);

  cap_state_e    st;
  cap_mode_e     run_mode;
  logic [AW-1:0] wp, trig_ptr, start_ptr, pre_cnt, post_cnt;
  logic [TW-1:0] to_cnt;
  logic          stop, wr, trig_hit, to_expired, fire, in_win;
  logic [AW-1:0] x_off;

  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // One extra bit holds the borrow/carry; a single +/-DEPTH fixes it up.
  function automatic logic [AW-1:0] sub_mod(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[AW]) d = d + DEP;
    return d[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DEP) s = s - DEP;
    return s[AW-1:0];
  endfunction

  assign stop       = (mode == MODE_STOP);
  assign wr         = bus.adc_valid && !stop && (st == ST_PRE || st == ST_ARMED || st == ST_POST);
  assign to_expired = (to_cnt == TW'(AUTO_TO - 1));
  assign fire       = wr && (st == ST_ARMED) && (trig_hit || (run_mode == MODE_AUTO && to_expired));
  assign cap_state  = st;

  trig_detect #(.DW(DW)) u_trig (
    .clk(clk), .rst(rst), .sample(bus.adc_data), .valid(bus.adc_valid),
    .level(trig_level), .slope(trig_slope), .en(st == ST_ARMED && !stop),
    .trig_hit(trig_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= ST_IDLE;
      run_mode       <= MODE_AUTO;
      wp             <= '0;
      trig_ptr       <= '0;
      start_ptr      <= '0;
      pre_cnt        <= '0;
      post_cnt       <= '0;
      to_cnt         <= '0;
      frame_ready    <= 1'b0;
      bus.ram_wren   <= 1'b0;
      bus.ram_wraddr <= '0;
      bus.ram_data   <= '0;
    end else begin
      bus.ram_wren <= wr;
      if (wr) begin
        bus.ram_wraddr <= wp;
        bus.ram_data   <= bus.adc_data;
        wp             <= inc_ptr(wp);
      end
      if (stop) st <= ST_IDLE;
      else begin
        case (st)
          ST_IDLE: if (mode == MODE_AUTO || mode == MODE_NORMAL || (mode == MODE_SINGLE && arm)) begin
            st          <= ST_PRE;
            run_mode    <= cap_mode_e'(mode);
            pre_cnt     <= '0;
            frame_ready <= 1'b0;
          end
          ST_PRE: if (wr) begin
            pre_cnt <= pre_cnt + AW'(1);
            if (pre_cnt == AW'(PRE_DEPTH - 1)) begin
              st     <= ST_ARMED;
              to_cnt <= '0;
            end
          end
          ST_ARMED: begin
            if (run_mode == MODE_AUTO && !to_expired) to_cnt <= to_cnt + TW'(1);
            if (fire) begin
              trig_ptr <= wp;
              post_cnt <= '0;
              st       <= ST_POST;
            end
          end
          ST_POST: if (wr) begin
            post_cnt <= post_cnt + AW'(1);
            if (post_cnt == AW'(DEPTH - PRE_DEPTH - 2)) begin
              st          <= ST_DONE;
              start_ptr   <= sub_mod(trig_ptr, AW'(PRE_DEPTH));
              frame_ready <= 1'b1;
            end
          end
          ST_DONE: if (((mode == MODE_AUTO || mode == MODE_NORMAL) && frame_sync) ||
                       (mode == MODE_SINGLE && arm)) begin
            st          <= ST_IDLE;
            frame_ready <= 1'b0;
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

  assign in_win = (value_x >= XLO) && (value_x < XHI);
  assign x_off  = AW'(value_x - XLO);

  always_ff @(posedge clk) begin
    if (rst)         bus.ram_rdaddr <= '0;
    else if (in_win) bus.ram_rdaddr <= add_mod(start_ptr, x_off);
  end
endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed + randomized bench for wave_capture_ctrl with a frame-level reference model.
module tb_wave_capture_ctrl;
  localparam int DEPTH = 200, PRE = 50, X0 = 100, AUTO_TO = 1000, PER = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] trig_level;
  logic       trig_slope;
  logic [1:0] mode;
  logic       arm, frame_sync;
  logic [9:0] value_x;
  logic       frame_ready;
  logic [2:0] cap_state;

  int checks = 0, errors = 0;
  int wa[$], wd[$], xs[$];
  int wp_m;

  always #5 clk = ~clk;

  wave_capture_ctrl_if #(.AW(8), .DW(8)) bus ();

  wave_capture_ctrl #(.AUTO_TO(AUTO_TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .trig_level(trig_level), .trig_slope(trig_slope),
    .mode(mode), .arm(arm), .frame_sync(frame_sync), .value_x(value_x),
    .frame_ready(frame_ready), .cap_state(cap_state)
  );

  always @(negedge clk) if (bus.ram_wren === 1'b1) begin
    wa.push_back(int'(bus.ram_wraddr));
    wd.push_back(int'(bus.ram_data));
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input int d);
    bus.adc_data  = d[7:0];
    bus.adc_valid = 1'b1;
    cyc();
    bus.adc_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1; cyc(); frame_sync = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; cyc(); arm = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int vx, input int exp);
    value_x = vx[9:0];
    cyc();
    chk(tag, int'(bus.ram_rdaddr), exp);
  endtask

  // First sample at/after the pre-trigger fill that crosses the level.
  function automatic int find_trig(input int lvl, input int slope);
    for (int i = PRE; i < xs.size(); i++) begin
      if (slope == 0 && xs[i-1] < lvl && xs[i] >= lvl) return i;
      if (slope == 1 && xs[i-1] > lvl && xs[i] <= lvl) return i;
    end
    return -1;
  endfunction

  // Feeds xs from the start of a capture and checks the whole frame.
  task automatic run_frame(input string tag, input int lvl, input int slope, input int gapmax);
    int k, n, bad, start, vx;
    trig_level = lvl[7:0];
    trig_slope = slope[0];
    k = find_trig(lvl, slope);
    chk({tag, "_found"}, int'(k >= 0), 1);
    if (k < 0) return;
    n = k + DEPTH - PRE;
    wa.delete(); wd.delete();
    for (int i = 0; i < n; i++) begin
      send(xs[i]);
      repeat ($urandom_range(0, gapmax)) cyc();
    end
    chk({tag, "_done"}, int'(cap_state), 4);
    chk({tag, "_ready"}, int'(frame_ready), 1);
    repeat (3) send($urandom_range(0, 255));
    cyc();
    chk({tag, "_nwr"}, wa.size(), n);
    bad = 0;
    for (int i = 0; i < n && i < wa.size(); i++)
      if (wa[i] != (wp_m + i) % DEPTH || wd[i] != xs[i]) bad++;
    chk({tag, "_wrseq"}, bad, 0);
    if (k < wd.size()) chk({tag, "_trigval"}, wd[k], xs[k]);
    start = (wp_m + k + DEPTH - PRE) % DEPTH;
    wp_m  = (wp_m + n) % DEPTH;
    read_chk({tag, "_start"}, X0, start);
    for (int j = 0; j < 3; j++) begin
      vx = $urandom_range(X0, X0 + DEPTH - 1);
      read_chk({tag, "_rd"}, vx, (start + vx - X0) % DEPTH);
    end
  endtask

  initial begin
    int n, k, bad, a;
    rst = 1'b1; mode = 2'd1; arm = 1'b0; frame_sync = 1'b0; value_x = '0;
    trig_level = 8'd128; trig_slope = 1'b0;
    bus.adc_data = '0; bus.adc_valid = 1'b0;
    wp_m = 0;
    repeat (3) cyc();
    chk("rst_state", int'(cap_state), 0);
    chk("rst_wren", int'(bus.ram_wren), 0);
    chk("rst_ready", int'(frame_ready), 0);
    chk("rst_rdaddr", int'(bus.ram_rdaddr), 0);
    chk("rst_wraddr", int'(bus.ram_wraddr), 0);
    rst = 1'b0;
    cyc(); cyc();

    // Flat history that wraps the RAM, then a step trigger.
    xs.delete();
    for (int i = 0; i < 230; i++) xs.push_back(10);
    for (int i = 0; i < 160; i++) xs.push_back(200);
    run_frame("wrap", 128, 0, 0);
    read_chk("map100", 100, 180);
    read_chk("map119", 119, 199);
    read_chk("map120", 120, 0);
    read_chk("map299", 299, 179);
    read_chk("map300", 300, 179);

    pulse_sync();
    chk("sync_state", int'(cap_state), 0);
    chk("sync_ready", int'(frame_ready), 0);
    cyc();
    xs.delete();
    for (int i = 0; i < 256; i++) xs.push_back(i);
    for (int i = 0; i < 40; i++) xs.push_back(255);
    run_frame("ramp", 128, 0, 1);

    for (int r = 0; r < 3; r++) begin
      pulse_sync(); cyc();
      xs.delete();
      for (int i = 0; i < 700; i++) xs.push_back($urandom_range(0, 255));
      run_frame($sformatf("rnd%0d", r), $urandom_range(40, 215), $urandom_range(0, 1), 2);
    end

    // Auto mode with a flat input: only the timeout can trigger.
    mode = 2'd0;
    pulse_sync(); cyc();
    wa.delete(); wd.delete();
    for (int i = 0; i < 3000 && frame_ready !== 1'b1; i++) begin
      send(50);
      repeat (PER - 1) cyc();
    end
    cyc();
    chk("auto_ready", int'(frame_ready), 1);
    n = wa.size();
    k = n - (DEPTH - PRE);
    a = k - PRE + 1;
    chk("auto_window", int'(a >= AUTO_TO / PER - 2 && a <= AUTO_TO / PER + 2), 1);
    bad = 0;
    for (int i = 0; i < n; i++) if (wa[i] != (wp_m + i) % DEPTH || wd[i] != 50) bad++;
    chk("auto_wrseq", bad, 0);
    read_chk("auto_start", X0, (wp_m + k + DEPTH - PRE) % DEPTH);
    wp_m = (wp_m + n) % DEPTH;

    // Single-shot: frame_sync ignored, arm releases and restarts.
    mode = 2'd2;
    pulse_sync();
    chk("ss_hold_state", int'(cap_state), 4);
    chk("ss_hold_ready", int'(frame_ready), 1);
    pulse_arm();
    chk("ss_rel_state", int'(cap_state), 0);
    chk("ss_rel_ready", int'(frame_ready), 0);
    wa.delete();
    repeat (20) send($urandom_range(0, 255));
    cyc();
    chk("ss_nowr", wa.size(), 0);
    chk("ss_idle", int'(cap_state), 0);
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        pulse_arm();
        chk("ss_back_idle", int'(cap_state), 0);
      end
      pulse_arm();
      chk("ss_pre", int'(cap_state), 1);
      xs.delete();
      for (int i = 0; i < 700; i++) xs.push_back($urandom_range(0, 255));
      run_frame($sformatf("ss%0d", r), $urandom_range(40, 215), $urandom_range(0, 1), 1);
    end

    // Stop: frozen frame stays flagged, no writes.
    mode = 2'd3;
    cyc();
    chk("stop_state", int'(cap_state), 0);
    chk("stop_ready", int'(frame_ready), 1);
    wa.delete();
    repeat (10) send($urandom_range(0, 255));
    cyc();
    chk("stop_nowr", wa.size(), 0);
    mode = 2'd1;
    cyc(); cyc();
    repeat (20) send($urandom_range(0, 255));
    cyc();
    chk("stop_pre_wr", wa.size(), 20);
    if (wa.size() > 0) chk("stop_pre_addr", wa[0], wp_m);
    mode = 2'd3;
    cyc();
    chk("stop_mid_state", int'(cap_state), 0);
    repeat (5) send(1);
    cyc();
    chk("stop_mid_nowr", wa.size(), 20);

    // Reset while in POST.
    mode = 2'd1;
    trig_level = 8'd128; trig_slope = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 140; i++) send(i);
    chk("rp_post", int'(cap_state), 3);
    rst = 1'b1;
    cyc();
    chk("rp_state", int'(cap_state), 0);
    chk("rp_wren", int'(bus.ram_wren), 0);
    chk("rp_ready", int'(frame_ready), 0);
    rst = 1'b0;
    wa.delete();
    cyc(); cyc();
    send(7);
    cyc();
    chk("rp_nwr", wa.size(), 1);
    if (wa.size() > 0) chk("rp_wp0", wa[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
